// File: rtl/hv_bundler_pkg.sv
// ============================================================================
// hv_bundler_pkg : default geometry and FSM encoding for the HDC temporal bundler
// Revision       : 1.0
// ============================================================================
`default_nettype none

package hv_bundler_pkg;

  localparam int C_HV_DIMENSION        = 2000;
  localparam int C_NUM_FRAMES          = 62;
  localparam int C_COUNT_WIDTH         = 6;
  localparam int C_BUN_NUM_FOLDS       = 8;
  localparam int C_BUN_NUM_FOLDS_WIDTH = 3;
  localparam int C_BUN_FOLD_WIDTH      = 250;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hv_majority_slice.sv
// ============================================================================
// hv_majority_slice : one fold of per-bit count update plus majority threshold
// Revision          : 1.0
// ============================================================================
`default_nettype none

module hv_majority_slice #(
  parameter int BUN_FOLD_WIDTH = 250,
  parameter int COUNT_WIDTH    = 6,
  parameter int NUM_FRAMES     = 62
) (
  input  logic [COUNT_WIDTH-1:0]    cnt_i [BUN_FOLD_WIDTH],
  input  logic [BUN_FOLD_WIDTH-1:0] bits_i,
  input  logic                      first_i,
  output logic [COUNT_WIDTH-1:0]    cnt_o [BUN_FOLD_WIDTH],
  output logic [BUN_FOLD_WIDTH-1:0] maj_o
);

  // 2*count is compared against NUM_FRAMES with two bits of headroom, so a tie yields 0
  localparam logic [COUNT_WIDTH+1:0] C_THRESH = (COUNT_WIDTH + 2)'(NUM_FRAMES);

  always_comb begin
    for (int j = 0; j < BUN_FOLD_WIDTH; j++) begin
      cnt_o[j] = first_i ? COUNT_WIDTH'(bits_i[j])
                         : cnt_i[j] + COUNT_WIDTH'(bits_i[j]);
      maj_o[j] = ({1'b0, cnt_o[j], 1'b0} > C_THRESH);
    end
  end

endmodule

`default_nettype wire

// File: rtl/hv_bundler.sv
// ============================================================================
// hv_bundler : folded per-bit majority bundling of NUM_FRAMES frame hypervectors
// Revision   : 1.0
// ============================================================================
`default_nettype none

module hv_bundler
  import hv_bundler_pkg::*;
#(
  parameter int NUM_FRAMES          = C_NUM_FRAMES,
  parameter int COUNT_WIDTH         = C_COUNT_WIDTH,
  parameter int BUN_NUM_FOLDS       = C_BUN_NUM_FOLDS,
  parameter int BUN_NUM_FOLDS_WIDTH = C_BUN_NUM_FOLDS_WIDTH,
  parameter int BUN_FOLD_WIDTH      = C_BUN_FOLD_WIDTH,
  parameter int HV_DIMENSION        = BUN_NUM_FOLDS * BUN_FOLD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    hvin_valid,
  output logic                    hvin_ready,
  input  logic [HV_DIMENSION-1:0] hvin,
  output logic                    hvout_valid,
  input  logic                    hvout_ready,
  output logic [HV_DIMENSION-1:0] hvout
);

  localparam int FCW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HIW = $clog2(HV_DIMENSION);
  localparam logic [FCW-1:0]                 C_LAST_FRAME = FCW'(NUM_FRAMES - 1);
  localparam logic [BUN_NUM_FOLDS_WIDTH-1:0] C_LAST_FOLD  = BUN_NUM_FOLDS_WIDTH'(BUN_NUM_FOLDS - 1);

  state_e                         state_q, state_d;
  logic [BUN_NUM_FOLDS_WIDTH-1:0] fold_cnt_q, fold_cnt_d;
  logic [FCW-1:0]                 frame_cnt_q, frame_cnt_d;
  logic [HV_DIMENSION-1:0]        hv_buf_q;
  logic [HV_DIMENSION-1:0]        hvout_q;
  logic [COUNT_WIDTH-1:0]         count_q [HV_DIMENSION];

  logic [HIW-1:0]                 w_base;
  logic [COUNT_WIDTH-1:0]         w_cnt_fold [BUN_FOLD_WIDTH];
  logic [COUNT_WIDTH-1:0]         w_cnt_nxt  [BUN_FOLD_WIDTH];
  logic [BUN_FOLD_WIDTH-1:0]      w_bits_fold;
  logic [BUN_FOLD_WIDTH-1:0]      w_maj;
  logic                           w_first, w_last_frame, w_last_fold;
  logic                           w_hvin_fire, w_hvout_fire;

  assign hvin_ready   = (state_q == ST_IDLE);
  assign hvout_valid  = (state_q == ST_OUT);
  assign hvout        = hvout_q;
  assign w_hvin_fire  = hvin_valid & hvin_ready;
  assign w_hvout_fire = hvout_valid & hvout_ready;

  assign w_first      = (frame_cnt_q == '0);
  assign w_last_frame = (frame_cnt_q == C_LAST_FRAME);
  assign w_last_fold  = (fold_cnt_q == C_LAST_FOLD);
  assign w_base       = HIW'(fold_cnt_q) * HIW'(BUN_FOLD_WIDTH);
  assign w_bits_fold  = hv_buf_q[w_base +: BUN_FOLD_WIDTH];

  always_comb begin
    for (int j = 0; j < BUN_FOLD_WIDTH; j++) begin
      w_cnt_fold[j] = count_q[w_base + HIW'(j)];
    end
  end

  // Single shared slice; the active fold is selected by fold_cnt
  hv_majority_slice #(
    .BUN_FOLD_WIDTH (BUN_FOLD_WIDTH),
    .COUNT_WIDTH    (COUNT_WIDTH),
    .NUM_FRAMES     (NUM_FRAMES)
  ) u_slice (
    .cnt_i   (w_cnt_fold),
    .bits_i  (w_bits_fold),
    .first_i (w_first),
    .cnt_o   (w_cnt_nxt),
    .maj_o   (w_maj)
  );

  always_comb begin
    state_d     = state_q;
    fold_cnt_d  = fold_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (w_hvin_fire) begin
          state_d    = ST_ACCUM;
          fold_cnt_d = '0;
        end
      end
      ST_ACCUM: begin
        if (w_last_fold) begin
          fold_cnt_d = '0;
          if (w_last_frame) begin
            state_d     = ST_OUT;
            frame_cnt_d = '0;
          end else begin
            state_d     = ST_IDLE;
            frame_cnt_d = frame_cnt_q + FCW'(1);
          end
        end else begin
          fold_cnt_d = fold_cnt_q + BUN_NUM_FOLDS_WIDTH'(1);
        end
      end
      ST_OUT: begin
        if (w_hvout_fire) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fold_cnt_q  <= '0;
      frame_cnt_q <= '0;
      hv_buf_q    <= '0;
      hvout_q     <= '0;
    end else begin
      state_q     <= state_d;
      fold_cnt_q  <= fold_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      if (w_hvin_fire) hv_buf_q <= hvin;
      if (state_q == ST_ACCUM && w_last_frame) hvout_q[w_base +: BUN_FOLD_WIDTH] <= w_maj;
    end
  end

  // Counters need no reset: the first frame of every window overwrites them
  always_ff @(posedge clk) begin
    if (state_q == ST_ACCUM) begin
      for (int j = 0; j < BUN_FOLD_WIDTH; j++) begin
        count_q[w_base + HIW'(j)] <= w_cnt_nxt[j];
      end
    end
  end

endmodule

`default_nettype wire
